// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared widths and types for the 8-to-3 priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam int N_IN  = 8;
    localparam int IDX_W = 3;

    typedef logic [N_IN-1:0]  req_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t C_IDX_RST = '0;
    localparam logic C_VLD_RST = 1'b0;

endpackage
`default_nettype wire

// File: rtl/priority_encoder_8x3_if.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_8x3_if
// Description : Request vector in, encoded index and valid flag out.
// Revision    : 1.0 - initial release
// ============================================================================
interface priority_encoder_8x3_if;
    import enc_pkg::*;

    req_t a;
    idx_t b;
    logic v;

    modport master (output a, input b, input v);
    modport slave  (input a, output b, output v);

endinterface
`default_nettype wire

// File: rtl/prio_enc_core.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_core
// Description : Combinational MSB-wins priority encode of an 8-bit request.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_core
    import enc_pkg::*;
(
    input  var req_t a,
    output idx_t     b_nxt,
    output logic     v_nxt
);

    // Anything not matching a one-bit-led pattern (all-zero, X) encodes to 0/0.
    always_comb begin
        b_nxt = C_IDX_RST;
        v_nxt = C_VLD_RST;
        casez (a)
            8'b1???????: begin b_nxt = 3'd7; v_nxt = 1'b1; end
            8'b01??????: begin b_nxt = 3'd6; v_nxt = 1'b1; end
            8'b001?????: begin b_nxt = 3'd5; v_nxt = 1'b1; end
            8'b0001????: begin b_nxt = 3'd4; v_nxt = 1'b1; end
            8'b00001???: begin b_nxt = 3'd3; v_nxt = 1'b1; end
            8'b000001??: begin b_nxt = 3'd2; v_nxt = 1'b1; end
            8'b0000001?: begin b_nxt = 3'd1; v_nxt = 1'b1; end
            8'b00000001: begin b_nxt = 3'd0; v_nxt = 1'b1; end
            default: begin
                b_nxt = C_IDX_RST;
                v_nxt = C_VLD_RST;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/priority_encoder_8x3.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_8x3
// Description : 8-input priority encoder, registered or combinational output.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_8x3
    import enc_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  wire                   clk,
    input  wire                   rst,
    priority_encoder_8x3_if.slave enc
);

    idx_t w_b_nxt;
    logic w_v_nxt;

    prio_enc_core u_core (
        .a     (enc.a),
        .b_nxt (w_b_nxt),
        .v_nxt (w_v_nxt)
    );

    generate
        if (REG_OUT) begin : g_reg
            idx_t r_b;
            logic r_v;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_b <= C_IDX_RST;
                    r_v <= C_VLD_RST;
                end else begin
                    r_b <= w_b_nxt;
                    r_v <= w_v_nxt;
                end
            end

            assign enc.b = r_b;
            assign enc.v = r_v;
        end else begin : g_bypass
            // Clock and reset have no effect in the bypass build.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk & rst;

            assign enc.b = w_b_nxt;
            assign enc.v = w_v_nxt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_8x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encoder_8x3
// Description : Scoreboard bench for registered and bypass encoder builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_8x3;
    import enc_pkg::*;

    typedef struct packed {
        idx_t b;
        logic v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    priority_encoder_8x3_if if_reg ();
    priority_encoder_8x3_if if_cmb ();

    priority_encoder_8x3 #(.REG_OUT(1'b1)) dut_reg (
        .clk (clk),
        .rst (rst),
        .enc (if_reg.slave)
    );

    priority_encoder_8x3 #(.REG_OUT(1'b0)) dut_cmb (
        .clk (clk),
        .rst (rst),
        .enc (if_cmb.slave)
    );

    always #5 clk = ~clk;

    // Reference: scan upward so the highest set bit is the last one recorded.
    function automatic exp_t model(input req_t x);
        exp_t r;
        r = '{b: 3'd0, v: 1'b0};
        for (int i = 0; i < N_IN; i++) begin
            if (x[i] === 1'b1) begin
                r.b = idx_t'(i);
                r.v = 1'b1;
            end
        end
        return r;
    endfunction

    // Drive one sample on the falling edge, queue its expectation, and return
    // just after the rising edge that registers it.
    task automatic apply(input req_t av, input logic rv, input exp_t e);
        @(negedge clk);
        if_reg.a = av;
        rst      = rv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t got;
        for (int k = 0; k < 2; k++) begin
            apply(8'hFF, 1'b1, '{b: 3'd0, v: 1'b0});
            e   = exp_q.pop_front();
            got = '{b: if_reg.b, v: if_reg.v};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got b=%0d v=%0b, want b=%0d v=%0b", k, got.b, got.v, e.b, e.v);
            end
        end
        apply(8'hFF, 1'b0, '{b: 3'd7, v: 1'b1});
        e   = exp_q.pop_front();
        got = '{b: if_reg.b, v: if_reg.v};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_release: got b=%0d v=%0b, want b=%0d v=%0b", got.b, got.v, e.b, e.v);
        end
    endtask

    task automatic test_onehot();
        exp_t e;
        exp_t got;
        req_t one;
        for (int i = 0; i < N_IN; i++) begin
            one = req_t'(1) << i;
            apply(one, 1'b0, '{b: idx_t'(i), v: 1'b1});
            e   = exp_q.pop_front();
            got = '{b: if_reg.b, v: if_reg.v};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL onehot a=%02h: got b=%0d v=%0b, want b=%0d v=%0b", one, got.b, got.v, e.b, e.v);
            end
        end
    endtask

    task automatic test_priority();
        req_t vec [4] = '{8'h81, 8'h3C, 8'h0F, 8'h06};
        idx_t idx [4] = '{3'd7, 3'd5, 3'd3, 3'd2};
        exp_t e;
        exp_t got;
        for (int i = 0; i < 4; i++) begin
            apply(vec[i], 1'b0, '{b: idx[i], v: 1'b1});
            e   = exp_q.pop_front();
            got = '{b: if_reg.b, v: if_reg.v};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL priority a=%02h: got b=%0d v=%0b, want b=%0d v=%0b", vec[i], got.b, got.v, e.b, e.v);
            end
        end
    endtask

    task automatic test_zero();
        exp_t e;
        exp_t got;
        apply(8'h00, 1'b0, '{b: 3'd0, v: 1'b0});
        e   = exp_q.pop_front();
        got = '{b: if_reg.b, v: if_reg.v};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL zero_in: got b=%0d v=%0b, want b=%0d v=%0b", got.b, got.v, e.b, e.v);
        end
        apply(8'h01, 1'b0, '{b: 3'd0, v: 1'b1});
        e   = exp_q.pop_front();
        got = '{b: if_reg.b, v: if_reg.v};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL bit0_in: got b=%0d v=%0b, want b=%0d v=%0b", got.b, got.v, e.b, e.v);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        exp_t got;
        apply(8'h12, 1'b0, '{b: 3'd4, v: 1'b1});
        e   = exp_q.pop_front();
        got = '{b: if_reg.b, v: if_reg.v};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL midrst_pre: got b=%0d v=%0b, want b=%0d v=%0b", got.b, got.v, e.b, e.v);
        end
        apply(8'h40, 1'b1, '{b: 3'd0, v: 1'b0});
        e   = exp_q.pop_front();
        got = '{b: if_reg.b, v: if_reg.v};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL midrst_drop: got b=%0d v=%0b, want b=%0d v=%0b", got.b, got.v, e.b, e.v);
        end
        apply(8'h40, 1'b0, '{b: 3'd6, v: 1'b1});
        e   = exp_q.pop_front();
        got = '{b: if_reg.b, v: if_reg.v};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL midrst_release: got b=%0d v=%0b, want b=%0d v=%0b", got.b, got.v, e.b, e.v);
        end
    endtask

    task automatic test_random();
        integer seed = 32'h5EED_1234;
        req_t   vec;
        exp_t   e;
        exp_t   got;
        for (int i = 0; i < 24; i++) begin
            vec = req_t'($random(seed));
            if (i == 3) vec = 8'h00;
            apply(vec, 1'b0, model(vec));
            e   = exp_q.pop_front();
            got = '{b: if_reg.b, v: if_reg.v};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL rand_reg[%0d] a=%02h: got b=%0d v=%0b, want b=%0d v=%0b", i, vec, got.b, got.v, e.b, e.v);
            end
            // Bypass build must follow its input with no clock in between.
            if_cmb.a = vec;
            #1;
            e   = model(vec);
            got = '{b: if_cmb.b, v: if_cmb.v};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL rand_cmb[%0d] a=%02h: got b=%0d v=%0b, want b=%0d v=%0b", i, vec, got.b, got.v, e.b, e.v);
            end
        end
        // Bypass output ignores reset.
        rst      = 1'b1;
        if_cmb.a = 8'h24;
        #1;
        n_checks++;
        if (if_cmb.b !== 3'd5 || if_cmb.v !== 1'b1) begin
            n_fail++;
            $display("FAIL cmb_under_rst: got b=%0d v=%0b, want b=5 v=1", if_cmb.b, if_cmb.v);
        end
        rst = 1'b0;
    endtask

    initial begin
        if_reg.a = 8'hFF;
        if_cmb.a = 8'h00;
        rst      = 1'b1;
        test_reset();
        test_onehot();
        test_priority();
        test_zero();
        test_mid_reset();
        test_random();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
